vga_fb_arbiter: RTL
===================

Name: vga_fb_arbiter

Overview:
Shares one single-port synchronous framebuffer RAM between VGA scanout and a pixel writer, such as a draw engine or CPU bridge. It consumes the 640x480 sync controller's hCounter/vCounter/vidOn and issues scanout reads two clocks ahead of the beam. Scanout always has priority; writer traffic is buffered and drained into free RAM slots. The framebuffer is stored downscaled by 2^SCALE_SHIFT in each axis, and each stored word is replicated on screen.

Parameters:
DATA_WIDTH, 4, bits per pixel word (RAM data width).
SCALE_SHIFT, 2, log2 of the pixel replication factor per axis; default gives a 160x120 framebuffer.
ADDR_WIDTH, 15, RAM address width; must satisfy 2^ADDR_WIDTH >= FB_WORDS.

Ports:
clock  in  1  pixel clock (divided clock, same as the sync controller)
reset  in  1  asynchronous, active-low reset (block in reset while 0)
hCounter  in  10  horizontal position 0..799 from the sync controller
vCounter  in  10  vertical position 0..524 from the sync controller
vidOn  in  1  visible-area flag from the sync controller
wr_valid  in  1  writer request
wr_ready  out  1  writer may present a request; transfer occurs when wr_valid && wr_ready at a clock edge
wr_addr  in  ADDR_WIDTH  framebuffer word address, row*FB_W + col
wr_data  in  DATA_WIDTH  pixel word to write
mem_addr  out  ADDR_WIDTH  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data, valid 1 clock after the address is applied
pixel  out  DATA_WIDTH  colour for the current hCounter/vCounter; 0 when vidOn=0
wr_oob  out  1  sticky flag: an out-of-range write was dropped

Behaviour:
- Derived constants:
  - FB_W = 640>>SCALE_SHIFT
  - FB_H = 480>>SCALE_SHIFT
  - FB_WORDS = FB_W*FB_H
  - M = 2^SCALE_SHIFT-1
- Lookahead position, computed combinationally each cycle:
  - lx = hCounter+2; ly = vCounter.
  - If hCounter is 798 or 799: lx = hCounter-798 and ly = vCounter+1; if vCounter = 524, ly = 0.
- Fetch needed (fetch_now) when lx<640 AND ly<480 AND (lx & M)==0.
  - Fetch address = (ly>>SCALE_SHIFT)*FB_W + (lx>>SCALE_SHIFT).
- Slot arbitration each cycle (the RAM port is never idle-driven with X):
  - fetch_now=1: mem_addr = fetch address, mem_we=0. Scanout always wins.
  - Else if the write buffer is valid: mem_addr = buf_addr, mem_wdata = buf_data, mem_we=1; buffer clears at this edge.
  - Else: mem_addr = 0, mem_we = 0.
- Write buffer: one entry (buf_valid, buf_addr, buf_data).
  - wr_ready = !buf_valid, registered-state based; no combinational path from wr_valid.
  - On accept, if wr_addr >= FB_WORDS: request is consumed, buf_valid stays 0, wr_oob set to 1 (cleared only by reset).
  - Otherwise buf_valid <= 1.
  - Accept and drain are never simultaneous (wr_ready=0 while valid). Peak write throughput is 1 per 2 clocks.
- Scanout pipeline:
  - fetch_d1 <= fetch_now.
  - If fetch_d1, pix_q <= mem_rdata; else pix_q holds. This gives replication across M+1 columns.
  - pixel = vidOn ? pix_q : 0.
  - Latency: a fetch issued at cycle t is displayed at t+2, when hCounter equals that cycle's lx.
- Vertical replication: the same row address is re-fetched on each of the 2^SCALE_SHIFT scanlines.
- Write-after-read: a write landing in a slot does not disturb a fetch already in flight; RAM is read-before-write, not required since slots never overlap.
- Reset (reset=0, async):
  - buf_valid=0, wr_ready=0 while in reset, wr_oob=0, fetch_d1=0, pix_q=0.
  - pixel=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - wr_ready goes 1 on the first clock after reset release.
- Reset mid-transfer: a pending buffered write is discarded (not written).
- Blanking (h 640..797 of a visible line, all of lines 480..524 except h 798/799 of line 524): every cycle is a write slot.

Test Plan:
- Reset held 0 with clock toggling -> pixel=0, mem_we=0, wr_ready=0, wr_oob=0; after release wr_ready=1 on the next clock.
- Preload RAM word 0=0xA, 1=0x5; run from (h=798,v=524) -> fetch addr 0 issued at h=798 and addr 1 at h=2. pixel=0xA for h=0..3 and 0x5 for h=4..7 of line 0.
- Write addr 161, data 0x7 during active video at h=100,v=4 (lx=102 no fetch) -> mem_we=1 with mem_addr=161 at the first non-fetch cycle. Readback shows pixel=0x7 at h=4..7, v=4..7.
- wr_valid held continuously across a visible line -> mem_we never asserted in a fetch cycle; writes retire 1 per 2 clocks in gaps.
- Write addr 19200 (=FB_WORDS) -> accepted, no mem_we, wr_oob=1 and stays 1; the next valid write proceeds normally.
- Accept a write, then pull reset low before drain -> no mem_we for it; after release buf empty, wr_ready=1.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: VGA scanout reads run two clocks ahead of the beam,
// and a one-entry write buffer drains into any cycle scanout does not need.
module vga_fb_arbiter #(
    parameter int DATA_WIDTH  = 4,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_WIDTH  = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [9:0]            hCounter,
    input  logic [9:0]            vCounter,
    input  logic                  vidOn,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] pixel,
    output logic                  wr_oob
);

    localparam int FB_W     = 640 >> SCALE_SHIFT;
    localparam int FB_H     = 480 >> SCALE_SHIFT;
    localparam int FB_WORDS = FB_W * FB_H;
    localparam int M        = (1 << SCALE_SHIFT) - 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wrReq_t;

    logic [9:0]            lx;
    logic [9:0]            ly;
    logic                  fetchNow;
    logic [ADDR_WIDTH-1:0] fetchAddr;

    wrReq_t                bufQ;
    logic                  bufValid;
    logic                  rdyEn;
    logic                  oobQ;
    logic                  fetchD1;
    logic [DATA_WIDTH-1:0] pixQ;

    logic                  accept;
    logic                  drain;
    logic                  addrOob;

    // Position the beam will be at two clocks from now, wrapping across line/frame ends.
    always_comb begin
        lx = hCounter + 10'd2;
        ly = vCounter;
        if (hCounter >= 10'd798) begin
            lx = hCounter - 10'd798;
            ly = (vCounter == 10'd524) ? 10'd0 : vCounter + 10'd1;
        end
    end

    // Gated by reset so the RAM port sits at address 0 while the block is held.
    assign fetchNow  = reset && (lx < 10'd640) && (ly < 10'(FB_H << SCALE_SHIFT))
                       && ((lx & 10'(M)) == 10'd0);
    assign fetchAddr = ADDR_WIDTH'(ly >> SCALE_SHIFT) * ADDR_WIDTH'(FB_W)
                     + ADDR_WIDTH'(lx >> SCALE_SHIFT);

    assign wr_ready = rdyEn & ~bufValid;
    assign accept   = wr_valid & wr_ready;
    assign drain    = bufValid & ~fetchNow;
    assign addrOob  = 32'(wr_addr) >= 32'(FB_WORDS);

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (fetchNow) begin
            mem_addr = fetchAddr;
        end else if (drain) begin
            mem_addr  = bufQ.addr;
            mem_we    = 1'b1;
            mem_wdata = bufQ.data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bufQ     <= '0;
            bufValid <= 1'b0;
            rdyEn    <= 1'b0;
            oobQ     <= 1'b0;
            fetchD1  <= 1'b0;
            pixQ     <= '0;
        end else begin
            rdyEn   <= 1'b1;
            fetchD1 <= fetchNow;
            // Holding between fetches replicates each word across M+1 columns.
            if (fetchD1)
                pixQ <= mem_rdata;
            // Accept only happens with the buffer empty, so it never races a drain.
            if (accept) begin
                if (addrOob) begin
                    oobQ <= 1'b1;
                end else begin
                    bufValid  <= 1'b1;
                    bufQ.addr <= wr_addr;
                    bufQ.data <= wr_data;
                end
            end else if (drain) begin
                bufValid <= 1'b0;
            end
        end
    end

    assign pixel  = vidOn ? pixQ : '0;
    assign wr_oob = oobQ;

endmodule
